reg_dump_unit: RTL and testbench
================================

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter FIRST_REG, default 8, first register number dumped.
REQ-002 Parameter LAST_REG, default 23, last register number dumped.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dump_req  input  1  request to start one dump; sampled only in IDLE.
REQ-006 pc_in  input  32  current program counter from the processor.
REQ-007 rf_addr  output  5  read address to the register file's combinational read port.
REQ-008 rf_data  input  32  register file read data for rf_addr, same cycle.
REQ-009 out_valid  output  1  out_index/out_data hold a valid dump word.
REQ-010 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-011 out_index  output  6  word tag: 0-31 register number, 32 PC.
REQ-012 out_data  output  32  word payload.
REQ-013 busy  output  1  high in every state except IDLE; top level stalls the processor while high.
REQ-014 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SEND and DONE (PC_SEND added under REQ-030).
REQ-016 In IDLE, dump_req=1 SHALL load the index counter with FIRST_REG and move to LOAD on the next edge.
REQ-017 rf_addr SHALL equal the index counter's lower 5 bits in every state.
REQ-018 LOAD SHALL register out_data<=rf_data and out_index<={1'b0,index}, set out_valid, and move to SEND; LOAD lasts exactly one cycle.
REQ-019 In SEND, out_valid, out_index and out_data SHALL hold stable until out_valid&&out_ready.
REQ-020 On a SEND handshake with index==LAST_REG, the FSM SHALL clear out_valid and move to DONE; otherwise it SHALL increment index, clear out_valid and return to LOAD.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 Latency: dump_req accepted at edge N gives out_valid=1 after edge N+2. With out_ready held high, each register word takes 2 cycles.
REQ-023 dump_req while busy SHALL be ignored and SHALL NOT queue. dump_req in the DONE cycle is ignored.
REQ-024 FIRST_REG==LAST_REG SHALL produce exactly one register word.
REQ-025 Register 0 SHALL be dumped as whatever rf_data returns; no special casing.
REQ-026 FIRST_REG>LAST_REG, or either parameter outside 0..31, is illegal; the design SHALL flag it with an elaboration-time check.

Reset
REQ-027 Reset SHALL force IDLE, index=FIRST_REG, out_valid=0, out_index=0, out_data=0, busy=0, done=0, rf_addr=FIRST_REG[4:0] after the edge.
REQ-028 Reset asserted mid-dump SHALL abort the dump on that edge. No further words and no done pulse SHALL follow.

Configuration
REQ-029 Macro REG_DUMP_PC_EN SHALL control whether the PC word is included.
REQ-030 With REG_DUMP_PC_EN defined:
- Accepting dump_req SHALL capture pc_in into out_data and set out_index=32 and out_valid=1.
- The FSM SHALL enter PC_SEND.
- The PC_SEND handshake SHALL move to LOAD with index=FIRST_REG.
- The PC word SHALL precede all register words. First out_valid comes after edge N+1.
REQ-031 Without REG_DUMP_PC_EN, PC_SEND SHALL NOT exist, pc_in SHALL be unused, and index 32 SHALL never appear.

Structure
REQ-032 Package reg_dump_pkg SHALL hold:
- the state enum typedef
- PC_INDEX=6'd32
- register-number constants for $t0=8, $s0=16 and $s7=23
REQ-033 No sub-module is natural. The counter and FSM SHALL live in reg_dump_unit.

Verification
REQ-034 Defaults, out_ready=1, regs 8..23 preloaded with 0x100+n, dump_req pulse -> 16 words, index 8..23, data 0x108..0x117, one word every 2 cycles, then done for 1 cycle.
REQ-035 out_ready low for 5 cycles on the word with index 12 -> out_index=12 and out_data=0x10C stay stable throughout; no word skipped or duplicated.
REQ-036 dump_req re-pulsed mid-dump and again in the DONE cycle -> ignored; exactly 16 words total.
REQ-037 Reset asserted after the third handshake -> out_valid=0 and busy=0 after the edge; no done pulse; a following dump restarts at index 8.
REQ-038 FIRST_REG=LAST_REG=31, reg31=0xDEADBEEF -> a single word with index 31 and data 0xDEADBEEF, then done.
REQ-039 REG_DUMP_PC_EN defined, pc_in=0x00400020 at request -> first word has index 32 and data 0x00400020, then registers 8..23; 17 words total.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// ============================================================================
// reg_dump_pkg
// Shared types and constants for the register dump unit: FSM state encoding,
// the PC word tag and MIPS register-number aliases.
// Optional feature macro: REG_DUMP_PC_EN (adds the PC_SEND state).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_dump_pkg;

  // Width of a register number and of an output word tag.
  localparam int REG_NUM_W = 5;
  localparam int TAG_W     = 6;

  // Raw state encodings, kept as plain constants for legacy tools and
  // waveform decoders that expect fixed numeric values.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
`ifdef REG_DUMP_PC_EN
  localparam logic [2:0] S_PC_SEND = 3'd4;
`endif

  // FSM state type; values pinned to the raw encodings above.
  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_LOAD    = S_LOAD,
    ST_SEND    = S_SEND,
`ifdef REG_DUMP_PC_EN
    ST_PC_SEND = S_PC_SEND,
`endif
    ST_DONE    = S_DONE
  } dump_state_e;

  // Tag value used for the program-counter word.
  localparam logic [TAG_W-1:0] PC_INDEX = 6'd32;

  // MIPS register-number aliases.
  localparam logic [REG_NUM_W-1:0] REG_T0 = 5'd8;
  localparam logic [REG_NUM_W-1:0] REG_S0 = 5'd16;
  localparam logic [REG_NUM_W-1:0] REG_S7 = 5'd23;

  // Builds a word tag from a register number (register tags never set bit 5).
  function automatic logic [TAG_W-1:0] reg_tag(input logic [REG_NUM_W-1:0] reg_num);
    return {1'b0, reg_num};
  endfunction

endpackage : reg_dump_pkg

`default_nettype wire

// File: rtl/reg_dump_unit.sv
// ============================================================================
// reg_dump_unit
// Walks register numbers FIRST_REG..LAST_REG through the register file's
// combinational read port and streams each value out over a valid/ready
// interface, optionally preceded by the captured program counter.
// Optional feature macro: REG_DUMP_PC_EN (emit a PC word, tag 32, first).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 8,
  parameter int LAST_REG  = 23
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dump_req,
  input  logic [31:0]          pc_in,
  output logic [REG_NUM_W-1:0] rf_addr,
  input  logic [31:0]          rf_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_index,
  output logic [31:0]          out_data,
  output logic                 busy,
  output logic                 done
);

  // Reject illegal register ranges while elaborating.
  generate
    if ((FIRST_REG < 0) || (FIRST_REG > 31) ||
        (LAST_REG  < 0) || (LAST_REG  > 31) ||
        (FIRST_REG > LAST_REG)) begin : g_bad_range
      $error("reg_dump_unit: illegal register range FIRST_REG=%0d LAST_REG=%0d",
             FIRST_REG, LAST_REG);
    end
  endgenerate

  localparam logic [REG_NUM_W-1:0] FIRST_IDX = FIRST_REG[REG_NUM_W-1:0];
  localparam logic [REG_NUM_W-1:0] LAST_IDX  = LAST_REG[REG_NUM_W-1:0];

  dump_state_e          state;
  dump_state_e          state_nxt;
  logic [REG_NUM_W-1:0] index;
  logic                 handshake;
  logic                 at_last;

  assign handshake = out_valid && out_ready;
  assign at_last   = (index == LAST_IDX);

`ifndef REG_DUMP_PC_EN
  // PC is not part of the dump in this build; fold it into a sink.
  logic pc_in_unused;
  assign pc_in_unused = ^pc_in;
`endif

  // Next-state selection; LOAD always lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dump_req) begin
`ifdef REG_DUMP_PC_EN
          state_nxt = ST_PC_SEND;
`else
          state_nxt = ST_LOAD;
`endif
        end
      end
`ifdef REG_DUMP_PC_EN
      ST_PC_SEND: begin
        if (handshake) begin
          state_nxt = ST_LOAD;
        end
      end
`endif
      ST_LOAD: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          state_nxt = at_last ? ST_DONE : ST_LOAD;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Register-number counter driving the register file read address.
  always_ff @(posedge clock) begin
    if (reset) begin
      index <= FIRST_IDX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dump_req) begin
            index <= FIRST_IDX;
          end
        end
`ifdef REG_DUMP_PC_EN
        ST_PC_SEND: begin
          if (handshake) begin
            index <= FIRST_IDX;
          end
        end
`endif
        ST_SEND: begin
          // Never increments past LAST_IDX, so the 5-bit counter cannot wrap.
          if (handshake && !at_last) begin
            index <= index + 5'd1;
          end
        end
        default: begin
          index <= index;
        end
      endcase
    end
  end

  // Output word register: loaded in LOAD (or on request for the PC word),
  // held unchanged until the consumer accepts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      case (state)
`ifdef REG_DUMP_PC_EN
        ST_IDLE: begin
          if (dump_req) begin
            out_valid <= 1'b1;
            out_index <= PC_INDEX;
            out_data  <= pc_in;
          end
        end
        ST_PC_SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
          end
        end
`endif
        ST_LOAD: begin
          out_valid <= 1'b1;
          out_index <= reg_tag(index);
          out_data  <= rf_data;
        end
        ST_SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= out_valid;
        end
      endcase
    end
  end

  assign rf_addr = index;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

endmodule : reg_dump_unit

`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
// ============================================================================
// tb_reg_dump_unit
// Directed-plus-random bench for reg_dump_unit. A behavioural model builds
// the expected word list straight from the register range and register file
// contents; every accepted word is checked against it in order.
// Optional feature macro: REG_DUMP_PC_EN (expects a leading PC word).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_dump_unit;

  localparam int FR = 8;
  localparam int LR = 23;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dump_req = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic [5:0]  out_index;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  // Second instance: single-register range at the top of the file.
  logic        dump_req_b = 1'b0;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_b;
  logic        out_valid_b;
  logic [5:0]  out_index_b;
  logic [31:0] out_data_b;
  logic        busy_b;
  logic        done_b;

  logic [31:0] rf_mem [32];

  assign rf_data   = rf_mem[rf_addr];
  assign rf_data_b = (rf_addr_b == 5'd31) ? 32'hDEADBEEF : 32'h0;

  always #5 clock = ~clock;

  reg_dump_unit #(.FIRST_REG(FR), .LAST_REG(LR)) dut (
    .clock(clock), .reset(reset), .dump_req(dump_req), .pc_in(pc_in),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done)
  );

  reg_dump_unit #(.FIRST_REG(31), .LAST_REG(31)) dut_b (
    .clock(clock), .reset(reset), .dump_req(dump_req_b), .pc_in(pc_in),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .out_valid(out_valid_b),
    .out_ready(1'b1), .out_index(out_index_b), .out_data(out_data_b),
    .busy(busy_b), .done(done_b)
  );

  int compared = 0;
  int mismatched = 0;
  logic [5:0]  q_idx [$];
  logic [31:0] q_dat [$];
  int words = 0;
  int cyc = 0;
  int last_hs = -1;
  bit check_spacing = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: optional PC word, then every register in range in order.
  task automatic build_expected();
    q_idx.delete();
    q_dat.delete();
`ifdef REG_DUMP_PC_EN
    q_idx.push_back(6'd32);
    q_dat.push_back(pc_in);
`endif
    for (int r = FR; r <= LR; r++) begin
      q_idx.push_back(6'(r));
      q_dat.push_back(rf_mem[r]);
    end
  endtask

  // One clock: account for a handshake at the coming edge, then check
  // done and word stability after it.
  task automatic cycle();
    bit hs, hold, lasths;
    logic [5:0]  pidx;
    logic [31:0] pdat;
    hs     = !reset && (out_valid === 1'b1) && out_ready;
    hold   = !reset && (out_valid === 1'b1) && !out_ready;
    pidx   = out_index;
    pdat   = out_data;
    lasths = 1'b0;
    if (hs) begin
      if (q_idx.size() != 0) begin
        chk("word_index", 64'(out_index), 64'(q_idx[0]));
        chk("word_data", 64'(out_data), 64'(q_dat[0]));
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
        lasths = (q_idx.size() == 0);
      end
      if (check_spacing && last_hs >= 0) chk("word_spacing", 64'(cyc - last_hs), 64'd2);
      last_hs = cyc;
      words++;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (!reset) chk("done_pulse", 64'(done), 64'(lasths));
    if (hold) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_index", 64'(out_index), 64'(pidx));
      chk("hold_data", 64'(out_data), 64'(pdat));
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: stall 5 cycles on register 12.
  task automatic run_dump(input int mode, input bit repulse);
    bit finished;
    int stall;
    finished = 1'b0;
    stall = 0;
    pc_in = $urandom;
    build_expected();
    words = 0;
    last_hs = -1;
    check_spacing = (mode == 0);
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    dump_req = 1'b1;
    cycle();
    dump_req = 1'b0;
    pc_in = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
`ifdef REG_DUMP_PC_EN
    chk("valid_after_accept", 64'(out_valid), 64'd1);
`else
    chk("valid_after_accept", 64'(out_valid), 64'd0);
    cycle();
    chk("valid_after_load", 64'(out_valid), 64'd1);
`endif
    for (int n = 0; n < 400 && !finished; n++) begin
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && out_index == 6'd12 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      dump_req = repulse && (n == 6);
      cycle();
      if (done === 1'b1) finished = 1'b1;
    end
    dump_req = 1'b0;
    chk("dump_finished", 64'(finished), 64'd1);
`ifdef REG_DUMP_PC_EN
    chk("word_total", 64'(words), 64'(LR - FR + 2));
`else
    chk("word_total", 64'(words), 64'(LR - FR + 1));
`endif
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd5);
    // Request during the DONE cycle must be dropped.
    dump_req = repulse;
    cycle();
    dump_req = 1'b0;
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("valid_after_done", 64'(out_valid), 64'd0);
    cycle();
    chk("still_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int n_b, d_b;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h100 + 32'(r);

    // Reset state.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rf_addr", 64'(rf_addr), 64'(FR));
    chk("rst_rf_addr_b", 64'(rf_addr_b), 64'd31);
    cycle();
    cycle();

    // Back-to-back dump with preloaded 0x100+n values.
    run_dump(0, 1'b0);
    // Consumer stall on register 12.
    run_dump(2, 1'b0);
    // Requests mid-dump and during DONE are ignored.
    run_dump(0, 1'b1);

    // Random contents with random back-pressure.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
      run_dump(1, 1'b0);
    end

    // Reset after the third accepted word aborts the dump.
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h100 + 32'(r);
    pc_in = $urandom;
    build_expected();
    words = 0;
    last_hs = -1;
    check_spacing = 1'b0;
    out_ready = 1'b1;
    dump_req = 1'b1;
    cycle();
    dump_req = 1'b0;
    for (int n = 0; n < 50 && words < 3; n++) cycle();
    chk("three_words_seen", 64'(words), 64'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rf_addr", 64'(rf_addr), 64'(FR));
    for (int n = 0; n < 8; n++) begin
      cycle();
      chk("abort_quiet", 64'(out_valid), 64'd0);
    end
    q_idx.delete();
    q_dat.delete();
    run_dump(0, 1'b0);

    // Single-register range on the second instance.
    n_b = 0;
    d_b = 0;
    dump_req_b = 1'b1;
    cycle();
    dump_req_b = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid_b) begin
`ifdef REG_DUMP_PC_EN
        if (n_b == 0) chk("b_pc_index", 64'(out_index_b), 64'd32);
        else begin
          chk("b_index", 64'(out_index_b), 64'd31);
          chk("b_data", 64'(out_data_b), 64'hDEADBEEF);
        end
`else
        chk("b_index", 64'(out_index_b), 64'd31);
        chk("b_data", 64'(out_data_b), 64'hDEADBEEF);
`endif
        n_b++;
      end
      cycle();
      if (done_b) d_b++;
    end
`ifdef REG_DUMP_PC_EN
    chk("b_word_total", 64'(n_b), 64'd2);
`else
    chk("b_word_total", 64'(n_b), 64'd1);
`endif
    chk("b_done_count", 64'(d_b), 64'd1);
    chk("b_idle", 64'(busy_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_reg_dump_unit

`default_nettype wire
